// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into one-cycle event pulses.
// A single shared counter times the long-press hold, the double-click gap and the auto-repeat period.
module button_event_decoder #(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned LONG_CYCLES    = 50000000,
    parameter int unsigned DBL_GAP_CYCLES = 12500000,
    parameter int unsigned REPEAT_CYCLES  = 10000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       double_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_WAIT_SECOND    = 3'd2,
        ST_SECOND_PRESSED = 3'd3,
        ST_LONG_HELD      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DBL_GAP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic             REPEAT_EN   = (REPEAT_CYCLES != 32'd0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_d;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_double;
    logic             r_long;
    logic             r_repeat;

    logic             w_rise;
    logic             w_fall;

    assign w_rise = btn & ~r_btn_d;
    assign w_fall = ~btn & r_btn_d;

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_press   = r_short;
    assign double_click  = r_double;
    assign long_press    = r_long;
    assign repeat_pulse  = r_repeat;
    assign state_o       = r_state;

    // Gesture FSM: state, shared timer, edge-detect history and registered event pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_btn_d   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_btn_d   <= btn;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= CNT_ZERO;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_state   <= ST_WAIT_SECOND;
                        r_cnt     <= CNT_ZERO;
                        r_release <= 1'b1;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= ST_LONG_HELD;
                        r_cnt   <= CNT_ZERO;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                // A rise on the timeout edge still counts as the second press.
                ST_WAIT_SECOND: begin
                    if (w_rise) begin
                        r_state <= ST_SECOND_PRESSED;
                        r_cnt   <= CNT_ZERO;
                        r_press <= 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_short <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_SECOND_PRESSED: begin
                    if (w_fall) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= CNT_ZERO;
                        r_release <= 1'b1;
                        r_double  <= 1'b1;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= ST_LONG_HELD;
                        r_cnt   <= CNT_ZERO;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_fall) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= CNT_ZERO;
                        r_release <= 1'b1;
                    end else if (REPEAT_EN && (r_cnt == REPEAT_LAST)) begin
                        r_cnt    <= CNT_ZERO;
                        r_repeat <= 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt    <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule
